// File: rtl/ibuf_fill_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ibuf_fill_ctrl
// Purpose  : Instruction-buffer fill controller; streams one aligned block from
//            the arbiter fetch port and serves per-word-valid issue reads.
// Revision : 1.0 - initial release
// ============================================================================
module ibuf_fill_ctrl #(
  parameter int WORDS = 16,
  parameter int AW    = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_fetch_req,
  input  logic [AW-1:0] i_fetch_addr,
  output logic          o_fetch_busy,
  input  logic          i_invalidate,
  output logic [AW-1:0] o_instr0_addr,
  output logic          o_instr0_req,
  input  logic          i_instr0_addr_ack,
  input  logic          i_instr0_ack,
  input  logic [63:0]   i_read_instr0_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic          o_rd_hit,
  output logic [63:0]   o_rd_data
);

  localparam int c_iw = $clog2(WORDS);
  localparam int c_tw = AW - c_iw;

  localparam logic [c_iw:0] c_last = (c_iw+1)'(WORDS - 1);
  localparam logic [c_iw:0] c_one  = (c_iw+1)'(1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_fill  = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;

  if ((WORDS < 2) || (WORDS > 64) || ((WORDS & (WORDS - 1)) != 0)) begin : g_bad_words
    $error("ibuf_fill_ctrl: WORDS must be a power of two in 2..64");
  end

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [c_tw-1:0]  r_tag;
  logic             r_tag_v;
  logic [WORDS-1:0] r_valid;
  logic [c_iw:0]    r_issue_cnt;
  logic [c_iw:0]    r_ret_cnt;
  logic             r_kill;
  logic [63:0]      r_mem [WORDS];

  logic             w_fetch_go;
  logic             w_issue;
  logic             w_ret_wr;
  logic [c_iw-1:0]  w_ret_idx;
  logic [c_iw-1:0]  w_rd_idx;

  assign w_fetch_go = (r_state == c_st_idle) && i_fetch_req;
  assign w_issue    = (r_state == c_st_fill) && i_instr0_addr_ack;
  // The top counter bit guards against a stray return once the block is full.
  assign w_ret_wr   = (r_state != c_st_idle) && i_instr0_ack && !r_ret_cnt[c_iw];
  assign w_ret_idx  = r_ret_cnt[c_iw-1:0];
  assign w_rd_idx   = i_rd_addr[c_iw-1:0];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (i_fetch_req) w_next_state = c_st_fill;
      end
      c_st_fill: begin
        if (w_issue && (r_issue_cnt == c_last)) w_next_state = c_st_drain;
      end
      c_st_drain: begin
        if (w_ret_wr && (r_ret_cnt == c_last)) w_next_state = c_st_idle;
      end
      default: w_next_state = c_st_idle;
    endcase
  end

  // Output logic; req stays high through DRAIN so the final returns carry data.
  always_comb begin
    o_instr0_req  = 1'b0;
    o_instr0_addr = '0;
    case (r_state)
      c_st_fill: begin
        o_instr0_req  = 1'b1;
        o_instr0_addr = {r_tag, r_issue_cnt[c_iw-1:0]};
      end
      c_st_drain: begin
        o_instr0_req  = 1'b1;
        o_instr0_addr = {r_tag, {c_iw{1'b1}}};
      end
      default: begin
        o_instr0_req  = 1'b0;
        o_instr0_addr = '0;
      end
    endcase
  end

  assign o_fetch_busy = (r_state != c_st_idle);

  // Tag, valid and counters. An invalidate during a fill arms r_kill so the
  // remaining returns still land in the buffer but never become valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag       <= '0;
      r_tag_v     <= 1'b0;
      r_valid     <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_kill      <= 1'b0;
    end else if (w_fetch_go) begin
      r_tag       <= i_fetch_addr[AW-1:c_iw];
      r_tag_v     <= 1'b1;
      r_valid     <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_kill      <= 1'b0;
    end else begin
      if (w_issue) r_issue_cnt <= r_issue_cnt + c_one;
      if (w_ret_wr) r_ret_cnt <= r_ret_cnt + c_one;
      if (i_invalidate) begin
        r_tag_v <= 1'b0;
        r_valid <= '0;
        r_kill  <= 1'b1;
      end else if (w_ret_wr && !r_kill) begin
        r_valid[w_ret_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_ret_wr) r_mem[w_ret_idx] <= i_read_instr0_data;
  end

  assign o_rd_hit  = r_tag_v && (i_rd_addr[AW-1:c_iw] == r_tag) && r_valid[w_rd_idx];
  assign o_rd_data = r_mem[w_rd_idx];

endmodule
`default_nettype wire

// File: tb/tb_ibuf_fill_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ibuf_fill_ctrl
// Purpose  : Scoreboard bench for ibuf_fill_ctrl with a one-cycle-return arbiter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ibuf_fill_ctrl;

  localparam int WORDS = 16;
  localparam int AW    = 22;

  logic          clk;
  logic          rst;
  logic          i_fetch_req;
  logic [AW-1:0] i_fetch_addr;
  logic          o_fetch_busy;
  logic          i_invalidate;
  logic [AW-1:0] o_instr0_addr;
  logic          o_instr0_req;
  logic          i_instr0_addr_ack;
  logic          i_instr0_ack;
  logic [63:0]   i_read_instr0_data;
  logic [AW-1:0] i_rd_addr;
  logic          o_rd_hit;
  logic [63:0]   o_rd_data;

  ibuf_fill_ctrl #(.WORDS(WORDS), .AW(AW)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_fetch_req        (i_fetch_req),
    .i_fetch_addr       (i_fetch_addr),
    .o_fetch_busy       (o_fetch_busy),
    .i_invalidate       (i_invalidate),
    .o_instr0_addr      (o_instr0_addr),
    .o_instr0_req       (o_instr0_req),
    .i_instr0_addr_ack  (i_instr0_addr_ack),
    .i_instr0_ack       (i_instr0_ack),
    .i_read_instr0_data (i_read_instr0_data),
    .i_rd_addr          (i_rd_addr),
    .o_rd_hit           (o_rd_hit),
    .o_rd_data          (o_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic          hit;
    logic [63:0]   data;
  } rd_exp_t;

  logic [AW-1:0] addr_q[$];
  rd_exp_t       rd_q[$];

  int          ack_mode = 0;
  logic        phase    = 1'b0;
  logic [31:0] seed_g   = 32'h0;
  logic        pend     = 1'b0;
  logic [63:0] pend_data = 64'h0;

  function automatic logic [63:0] mkdata(input logic [31:0] s, input logic [AW-1:0] a);
    return {s, 10'h2A5, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input logic [AW-1:0] a, input logic hit, input logic [31:0] s);
    rd_exp_t e;
    i_rd_addr = a;
    e.addr = a;
    e.hit  = hit;
    e.data = mkdata(s, a);
    rd_q.push_back(e);
  endtask

  // Called in cycle 0; returns in the first fill cycle.
  task automatic start_fetch(input logic [AW-1:0] a, input logic [31:0] s, input bit push);
    seed_g = s;
    if (push) begin
      for (int i = 0; i < WORDS; i++) begin
        logic [AW-1:0] x;
        x = {a[AW-1:4], 4'(i)};
        addr_q.push_back(x);
      end
    end
    i_fetch_addr = a;
    i_fetch_req  = 1'b1;
    tick();
    i_fetch_req  = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (o_fetch_busy && (n < bound)) begin
      tick();
      n++;
    end
    check("wait_idle_busy", 64'(o_fetch_busy), 64'd0);
  endtask

  // Arbiter model: address ack per ack_mode, data exactly one cycle later.
  initial begin
    i_instr0_addr_ack  = 1'b0;
    i_instr0_ack       = 1'b0;
    i_read_instr0_data = 64'h0;
    forever begin
      @(posedge clk);
      #1;
      i_instr0_ack       = pend;
      i_read_instr0_data = pend_data;
      phase              = ~phase;
      i_instr0_addr_ack  = o_instr0_req && ((ack_mode == 0) || phase);
      pend               = i_instr0_addr_ack;
      pend_data          = mkdata(seed_g, o_instr0_addr);
    end
  end

  // Monitor: pops the scoreboards whenever the DUT presents an address or a read.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && o_instr0_req && i_instr0_addr_ack && (addr_q.size() > 0)) begin
        logic [AW-1:0] ea;
        ea = addr_q.pop_front();
        check($sformatf("fill_addr_%h", ea), 64'(o_instr0_addr), 64'(ea));
      end
      if (rd_q.size() > 0) begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check($sformatf("rd_hit_%h", e.addr), 64'(o_rd_hit), 64'(e.hit));
        if (e.hit) check($sformatf("rd_data_%h", e.addr), o_rd_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    i_fetch_req  = 1'b0;
    i_fetch_addr = '0;
    i_invalidate = 1'b0;
    i_rd_addr    = '0;
    repeat (3) tick();
    check("reset_req",  64'(o_instr0_req),  64'd0);
    check("reset_addr", 64'(o_instr0_addr), 64'd0);
    check("reset_busy", 64'(o_fetch_busy),  64'd0);
    check("reset_hit",  64'(o_rd_hit),      64'd0);
    rst = 1'b1;
    repeat (2) tick();

    // Full fill, continuous acks, early-restart reads and busy timing.
    ack_mode = 0;
    start_fetch(22'h000123, 32'd1, 1'b1);
    for (int k = 1; k <= 18; k++) begin
      if (k > 1) tick();
      if (k <= 4) probe(22'h000120, (k >= 3), 32'd1);
      else        probe(22'h00012F, (k == 18), 32'd1);
      check($sformatf("busy_c%0d", k), 64'(o_fetch_busy), 64'(k < 18));
      check($sformatf("req_c%0d", k),  64'(o_instr0_req),  64'(k < 18));
    end
    tick(); probe(22'h00012A, 1'b1, 32'd1);
    tick(); probe(22'h000120, 1'b1, 32'd1);
    tick(); probe(22'h00012F, 1'b1, 32'd1);

    // Toggling acks, plus a fetch request while busy that must be ignored.
    tick();
    ack_mode = 1;
    start_fetch(22'h000123, 32'd2, 1'b1);
    repeat (3) tick();
    i_fetch_addr = 22'h000555;
    i_fetch_req  = 1'b1;
    tick();
    i_fetch_req  = 1'b0;
    wait_idle(100);
    for (int i = 0; i < WORDS; i++) begin
      logic [AW-1:0] a;
      a = 22'h000120 + 22'(i);
      tick();
      probe(a, 1'b1, 32'd2);
    end
    tick(); probe(22'h000555, 1'b0, 32'd2);

    // Invalidate while idle.
    i_invalidate = 1'b1;
    tick();
    i_invalidate = 1'b0;
    probe(22'h00012A, 1'b0, 32'd2);

    // Invalidate mid-fill, then fetch together with invalidate (fetch wins).
    ack_mode = 0;
    tick();
    start_fetch(22'h000340, 32'd3, 1'b1);
    repeat (5) tick();
    i_invalidate = 1'b1;
    tick();
    i_invalidate = 1'b0;
    wait_idle(100);
    tick(); probe(22'h000340, 1'b0, 32'd3);
    tick(); probe(22'h000347, 1'b0, 32'd3);
    tick(); probe(22'h00034F, 1'b0, 32'd3);
    tick();
    i_invalidate = 1'b1;
    start_fetch(22'h000345, 32'd4, 1'b1);
    i_invalidate = 1'b0;
    wait_idle(100);
    tick(); probe(22'h00034A, 1'b1, 32'd4);
    tick(); probe(22'h000340, 1'b1, 32'd4);

    // Reset on the fifth fill cycle, then a fresh fill.
    tick();
    start_fetch(22'h000700, 32'd5, 1'b0);
    i_rd_addr = 22'h000700;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    check("rst_mid_req",  64'(o_instr0_req), 64'd0);
    check("rst_mid_busy", 64'(o_fetch_busy), 64'd0);
    check("rst_mid_hit",  64'(o_rd_hit),     64'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    start_fetch(22'h000705, 32'd6, 1'b1);
    wait_idle(100);
    tick(); probe(22'h00070F, 1'b1, 32'd6);
    tick(); probe(22'h000700, 1'b1, 32'd6);

    repeat (3) tick();
    check("addr_q_drained", 64'(addr_q.size()), 64'd0);
    check("rd_q_drained",   64'(rd_q.size()),   64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ibuf_fill_ctrl.md
# ibuf_fill_ctrl

Instruction-buffer fill controller for the Cray CPU fetch path. It sits directly upstream of the memory arbiter's instruction-fetch port. On a fetch request from the issue stage, it streams one aligned block of words from memory into a local word buffer. It serves issue-side word reads with per-word valid tracking, so instructions can issue from words that have already arrived before the whole block is filled.

## Interface
Parameters:
- WORDS, 16: buffer depth in 64-bit words. Must be a power of two, 2..64.
- AW, 22: word address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_fetch_req  in  1  single-cycle request from issue to load the block containing i_fetch_addr.
- i_fetch_addr  in  AW  any word address inside the requested block.
- o_fetch_busy  out  1  a fill is in progress; i_fetch_req is ignored while this is high.
- i_invalidate  in  1  clears all valid bits and the tag-valid flag.
- o_instr0_addr  out  AW  word address presented to the arbiter.
- o_instr0_req  out  1  read request to the arbiter.
- i_instr0_addr_ack  in  1  arbiter accepted the current address.
- i_instr0_ack  in  1  data-return strobe. Arrives exactly one cycle after the matching address ack.
- i_read_instr0_data  in  64  returned word; valid only while i_instr0_ack=1.
- i_rd_addr  in  AW  issue-side word read address.
- o_rd_hit  out  1  i_rd_addr is in the buffered block and that word is valid. Combinational.
- o_rd_data  out  64  buffer word at index i_rd_addr[log2(WORDS)-1:0]. Combinational.

## Operation
- State: tag (AW-log2(WORDS) bits), tag_v, valid[WORDS], issue_cnt, ret_cnt (each log2(WORDS)+1 bits), FSM IDLE/FILL/DRAIN.
- IDLE:
  - On i_fetch_req: latch the tag from i_fetch_addr and set tag_v=1.
  - Clear all valid bits and zero both counters.
  - Go to FILL.
- FILL:
  - o_instr0_req=1 and o_instr0_addr = {tag, issue_cnt[low bits]}.
  - Each i_instr0_addr_ack increments issue_cnt.
  - When an ack lands with issue_cnt=WORDS-1, go to DRAIN.
- DRAIN:
  - o_instr0_req stays 1, because the arbiter zeroes return data when req is low.
  - Address held at {tag, WORDS-1}.
  - Any further address acks are speculative reads and are not counted.
  - When ret_cnt reaches WORDS (the last return written), go to IDLE.
- Data return, in FILL or DRAIN:
  - Each i_instr0_ack writes i_read_instr0_data to buffer[ret_cnt], sets valid[ret_cnt] and increments ret_cnt.
  - Returns arrive in order. Acks seen in IDLE are ignored.
- o_rd_hit = tag_v & (i_rd_addr tag == tag) & valid[index].
- o_fetch_busy = (state != IDLE).
- i_invalidate:
  - In IDLE it clears tag_v and valid.
  - During FILL or DRAIN it clears valid and tag_v, and the fill runs to completion with writes landing but valid kept cleared until the next fetch.
  - If asserted in the same cycle as i_fetch_req in IDLE, the fetch wins.

## Timing
- Reset values: state IDLE, o_instr0_req 0, o_instr0_addr 0, o_fetch_busy 0, o_rd_hit 0, tag_v 0, all valid 0, counters 0.
- Fetch request to first o_instr0_req: 1 cycle.
- First address ack in cycle N gives data write in N+1 and o_rd_hit for that word in N+2.
- Full fill with continuous address acks: WORDS+2 cycles from i_fetch_req to o_fetch_busy=0.
- Arbiter stalls (addr_ack=0, e.g. MFU priority) extend FILL indefinitely. Address and req stay stable while stalled.
- Reset asserted mid-fill drops req immediately (asynchronously) and discards all state.
- Buffer read is same-cycle. Write-then-read of the same word is visible the next cycle.

## Test plan
- WORDS=16, reset released, fetch at 0x000123 with addr_ack held 1 → addresses 0x000120..0x00012F on consecutive cycles, req held through the last return, busy low 18 cycles after the request, and o_rd_hit=1 for 0x00012A with the returned data.
- Same fetch with addr_ack toggling 1,0,1,0 → 16 writes in order, no address skipped or duplicated, final ret_cnt=16.
- Early restart: read 0x000120 during the fill → hit=0 until cycle N+2 after the first ack, then 1. Read 0x00012F → 0 until the final return.
- Extra address ack during DRAIN → no 17th write, busy still clears, and the stray data ack in IDLE does not change valid.
- Fetch request while busy is ignored. i_invalidate mid-fill → hit=0 for all addresses after the fill. A new fetch then refills and hits.
- Reset pulled low on the 5th fill cycle → req and busy go 0 immediately and hit=0. After release, a fresh fetch completes normally.
